// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared request encodings, FSM states and byte-merge helper for mem_responder
package mem_responder_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } memresp_state_t;

  // Byte i of the result comes from wdata when wstrb[i] is set, otherwise from the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_resp_bram.sv
// rtl/mem_resp_bram.sv - single-port word RAM with byte write enables and READ_LAT registered read stages
module mem_resp_bram #(
  parameter int    ADDR_W    = 12,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];
  logic [31:0] pipe_q [READ_LAT];

  // Byte-enabled write, first read register (loaded only on pure reads), then a plain shift chain.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (be == 4'h0) begin
        pipe_q[0] <= mem[addr];
      end
    end
    for (int s = 1; s < READ_LAT; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rdata = pipe_q[READ_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder; optional MEM_RESP_RANGE_CHECK_EN flags out-of-range requests
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        protocol_err,
  output logic        range_err
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

  memresp_state_t    state_q, state_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              oor_q, oor_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              response_enable_q, response_enable_d;
  logic              protocol_err_q, protocol_err_d;
  logic              range_err_q, range_err_d;

  logic              ram_en;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic              busy_w;
  logic              req_oor;
  logic              unused_addr_bits;

`ifdef MEM_RESP_RANGE_CHECK_EN
  assign req_oor = |req_addr[31:ADDR_W+2];
`else
  assign req_oor = 1'b0;
`endif

  // Low address bits are byte offsets; high bits only matter to the range check.
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

  // The response cycle is still part of the current access, so it counts as busy.
  assign busy_w = (state_q != IDLE) || response_enable_q;

  // Next-state, RAM port and response computation.
  always_comb begin
    state_d           = state_q;
    lat_cnt_d         = lat_cnt_q;
    mode_d            = mode_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    wstrb_d           = wstrb_q;
    oor_d             = oor_q;
    resp_data_d       = resp_data_q;
    response_enable_d = 1'b0;
    range_err_d       = 1'b0;
    protocol_err_d    = protocol_err_q | (request_enable & busy_w);
    ram_en            = 1'b0;
    ram_be            = 4'h0;
    ram_addr          = addr_q;
    ram_wdata         = merge_bytes(ram_rdata, wdata_q, wstrb_q);

    case (state_q)
      IDLE: begin
        if (request_enable && !response_enable_q) begin
          mode_d    = req_mode;
          addr_d    = req_addr[ADDR_W+1:2];
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          oor_d     = req_oor;
          lat_cnt_d = LAT_LOAD;
          ram_en    = 1'b1;
          ram_addr  = req_addr[ADDR_W+1:2];
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          response_enable_d = 1'b1;
          resp_data_d       = oor_q ? 32'h0 : ram_rdata;
          range_err_d       = oor_q;
          state_d           = IDLE;
          // A reset on the commit edge must abandon the write.
          if (mode_q == MEMREQ_WRITE && !oor_q && rstn) begin
            ram_en = 1'b1;
            ram_be = 4'hF;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q           <= IDLE;
      lat_cnt_q         <= 2'd0;
      mode_q            <= MEMREQ_READ;
      addr_q            <= '0;
      wdata_q           <= 32'h0;
      wstrb_q           <= 4'h0;
      oor_q             <= 1'b0;
      resp_data_q       <= 32'h0;
      response_enable_q <= 1'b0;
      protocol_err_q    <= 1'b0;
      range_err_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      lat_cnt_q         <= lat_cnt_d;
      mode_q            <= mode_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      wstrb_q           <= wstrb_d;
      oor_q             <= oor_d;
      resp_data_q       <= resp_data_d;
      response_enable_q <= response_enable_d;
      protocol_err_q    <= protocol_err_d;
      range_err_q       <= range_err_d;
    end
  end

  mem_resp_bram #(
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT),
    .INIT_FILE(INIT_FILE)
  ) u_bram (
    .clk  (clk),
    .en   (ram_en),
    .be   (ram_be),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign response_enable = response_enable_q;
  assign resp_data       = resp_data_q;
  assign busy            = busy_w;
  assign protocol_err    = protocol_err_q;
  assign range_err       = range_err_q;

endmodule
